// File: rtl/exibe_sequencia_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exibe_sequencia_if                                         |
// | Description : Bus between the control unit / sequence memory and the     |
// |               sequence playback block.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface exibe_sequencia_if;
  logic       iniciar;
  logic       abortar;
  logic [3:0] rodada;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  // Control unit + memory side
  modport master (
    output iniciar, abortar, rodada, mem_dado,
    input  mem_endereco, leds, ocupado, pronto, db_estado
  );

  // Playback block side
  modport slave (
    input  iniciar, abortar, rodada, mem_dado,
    output mem_endereco, leds, ocupado, pronto, db_estado
  );
endinterface
`default_nettype wire

// File: rtl/exibe_sequencia.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : exibe_sequencia                                            |
// | Description : Plays back memory positions 0..rodada on the LEDs, each    |
// |               lit for T_ON cycles followed by a T_OFF-cycle blank gap,   |
// |               then pulses pronto for one cycle.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module exibe_sequencia #(
  parameter int T_ON  = 500,
  parameter int T_OFF = 250,
  parameter int T_W   = 16
) (
  input logic                 clock,
  input logic                 reset,
  exibe_sequencia_if.slave    bus
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'd0,
    CARREGA = 4'd1,
    ACESO   = 4'd2,
    APAGADO = 4'd3,
    FIM     = 4'd4
  } estado_t;

  localparam logic [T_W-1:0] C_ON_ULTIMO  = T_W'(T_ON - 1);
  localparam logic [T_W-1:0] C_OFF_ULTIMO = T_W'(T_OFF - 1);

  estado_t        r_estado,   w_estado;
  logic [T_W-1:0] r_timer,    w_timer;
  logic [3:0]     r_rodada,   w_rodada;
  logic [3:0]     r_led,      w_led;
  logic [3:0]     r_endereco, w_endereco;

  // State, timer, latched round length, latched pattern and address registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= OCIOSO;
      r_timer    <= '0;
      r_rodada   <= '0;
      r_led      <= '0;
      r_endereco <= '0;
    end else begin
      r_estado   <= w_estado;
      r_timer    <= w_timer;
      r_rodada   <= w_rodada;
      r_led      <= w_led;
      r_endereco <= w_endereco;
    end
  end

  // Next-state logic; abortar overrides every state, including a start request
  always_comb begin
    w_estado   = r_estado;
    w_timer    = r_timer;
    w_rodada   = r_rodada;
    w_led      = r_led;
    w_endereco = r_endereco;

    if (bus.abortar) begin
      w_estado = OCIOSO;
      w_timer  = '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            w_rodada   = bus.rodada;
            w_endereco = '0;
            w_estado   = CARREGA;
          end
        end
        CARREGA: begin
          // Memory is combinational: the data for r_endereco is valid now
          w_led    = bus.mem_dado;
          w_timer  = '0;
          w_estado = ACESO;
        end
        ACESO: begin
          if (r_timer == C_ON_ULTIMO) begin
            w_timer  = '0;
            w_estado = APAGADO;
          end else begin
            w_timer = r_timer + T_W'(1);
          end
        end
        APAGADO: begin
          if (r_timer == C_OFF_ULTIMO) begin
            w_timer = '0;
            // Last step reached: address stops at rodada, so it never wraps
            if (r_endereco == r_rodada) begin
              w_estado = FIM;
            end else begin
              w_endereco = r_endereco + 4'd1;
              w_estado   = CARREGA;
            end
          end else begin
            w_timer = r_timer + T_W'(1);
          end
        end
        FIM: begin
          w_estado = OCIOSO;
        end
        default: begin
          w_estado = OCIOSO;
          w_timer  = '0;
        end
      endcase
    end
  end

  // Moore output decodes from registered state only
  assign bus.leds         = (r_estado == ACESO) ? r_led : 4'd0;
  assign bus.pronto       = (r_estado == FIM);
  assign bus.ocupado      = (r_estado != OCIOSO);
  assign bus.db_estado    = r_estado;
  assign bus.mem_endereco = r_endereco;

endmodule
`default_nettype wire

// File: tb/tb_exibe_sequencia.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_exibe_sequencia                                         |
// | Description : Scoreboard bench for exibe_sequencia: a cycle-by-cycle     |
// |               expected trace is queued at each start and popped by a     |
// |               monitor on every falling edge.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_exibe_sequencia;

  localparam int TON0  = 4;
  localparam int TOFF0 = 2;
  localparam int TON1  = 1;
  localparam int TOFF1 = 1;

  typedef struct packed {
    logic [3:0] leds;
    logic [3:0] ende;
    logic       pronto;
    logic       ocupado;
    logic [3:0] estado;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exibe_sequencia_if bus0();
  exibe_sequencia_if bus1();

  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];

  obs_t sb0 [$];
  obs_t sb1 [$];
  obs_t act0, act1;

  int n_checks = 0;
  int n_fail   = 0;

  exibe_sequencia #(.T_ON(TON0), .T_OFF(TOFF0), .T_W(8)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  exibe_sequencia #(.T_ON(TON1), .T_OFF(TOFF1), .T_W(4)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  // Combinational memory models
  assign bus0.mem_dado = mem0[bus0.mem_endereco];
  assign bus1.mem_dado = mem1[bus1.mem_endereco];

  assign act0 = {bus0.leds, bus0.mem_endereco, bus0.pronto, bus0.ocupado, bus0.db_estado};
  assign act1 = {bus1.leds, bus1.mem_endereco, bus1.pronto, bus1.ocupado, bus1.db_estado};

  task automatic check_seq(input string name, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t: got leds=%b addr=%0d pronto=%b ocupado=%b estado=%0d, expected leds=%b addr=%0d pronto=%b ocupado=%b estado=%0d",
               name, $time, a.leds, a.ende, a.pronto, a.ocupado, a.estado,
               e.leds, e.ende, e.pronto, e.ocupado, e.estado);
    end
  endtask

  // Idle: address is free to hold any value, everything else must be quiet
  task automatic check_idle(input string name, input obs_t a);
    n_checks++;
    if (a.leds !== 4'd0 || a.pronto !== 1'b0 || a.ocupado !== 1'b0 || a.estado !== 4'd0) begin
      n_fail++;
      $display("FAIL %s t=%0t: got leds=%b pronto=%b ocupado=%b estado=%0d, expected all zero",
               name, $time, a.leds, a.pronto, a.ocupado, a.estado);
    end
  endtask

  task automatic put(input int which, input obs_t e);
    if (which == 0) sb0.push_back(e);
    else            sb1.push_back(e);
  endtask

  // Reference model: each step is one load cycle, ton lit cycles, toff blank
  // cycles; one pronto cycle closes the sequence.
  task automatic push_trace(input int which, input int rod, input int ton, input int toff);
    logic [3:0] pat;
    for (int k = 0; k <= rod; k++) begin
      pat = (which == 0) ? mem0[k] : mem1[k];
      put(which, {4'd0, 4'(k), 1'b0, 1'b1, 4'd1});
      for (int i = 0; i < ton; i++)  put(which, {pat,  4'(k), 1'b0, 1'b1, 4'd2});
      for (int i = 0; i < toff; i++) put(which, {4'd0, 4'(k), 1'b0, 1'b1, 4'd3});
    end
    put(which, {4'd0, 4'(rod), 1'b1, 1'b1, 4'd4});
  endtask

  // Monitors
  always @(negedge clock) begin
    if (reset) begin
      if (sb0.size() > 0) check_seq("seq0", act0, sb0.pop_front());
      else                check_idle("idle0", act0);
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (sb1.size() > 0) check_seq("seq1", act1, sb1.pop_front());
      else                check_idle("idle1", act1);
    end
  end

  // Called at posedge+1; leaves at posedge+1 after the start has been sampled
  task automatic start0(input int rod);
    bus0.rodada  = 4'(rod);
    bus0.iniciar = 1'b1;
    @(posedge clock);
    #1;
    bus0.iniciar = 1'b0;
    push_trace(0, rod, TON0, TOFF0);
  endtask

  task automatic drain(input int which, input int budget);
    int i = 0;
    while (((which == 0) ? sb0.size() : sb1.size()) > 0 && i < budget) begin
      @(posedge clock);
      i++;
    end
    #1;
    n_checks++;
    if (((which == 0) ? sb0.size() : sb1.size()) > 0) begin
      n_fail++;
      $display("FAIL drain%0d timeout: %0d entries left, expected 0",
               which, (which == 0) ? sb0.size() : sb1.size());
      if (which == 0) sb0.delete();
      else            sb1.delete();
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    bus0.iniciar = 1'b0; bus0.abortar = 1'b0; bus0.rodada = 4'd0;
    bus1.iniciar = 1'b0; bus1.abortar = 1'b0; bus1.rodada = 4'd0;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 4'd0;
      mem1[i] = 4'd0;
    end

    // Reset state while reset is held
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({bus0.leds, bus0.pronto, bus0.ocupado, bus0.mem_endereco, bus0.db_estado} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: got leds=%b pronto=%b ocupado=%b addr=%0d estado=%0d, expected all zero",
               bus0.leds, bus0.pronto, bus0.ocupado, bus0.mem_endereco, bus0.db_estado);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Single step
    mem0[0] = 4'b0001;
    start0(0);
    drain(0, 100);

    // Three steps
    mem0[0] = 4'b0001; mem0[1] = 4'b0100; mem0[2] = 4'b1000;
    start0(2);
    drain(0, 100);

    // Abort in ACESO of step 1, then a clean restart from address 0
    mem0[3] = 4'b0010;
    start0(3);
    repeat (9) @(posedge clock);
    #1;
    bus0.abortar = 1'b1;
    @(posedge clock);
    #1;
    bus0.abortar = 1'b0;
    sb0.delete();
    n_checks++;
    if (bus0.ocupado !== 1'b0 || bus0.leds !== 4'd0 || bus0.pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got ocupado=%b leds=%b pronto=%b, expected 0 0 0",
               bus0.ocupado, bus0.leds, bus0.pronto);
    end
    repeat (3) @(posedge clock);
    #1;
    start0(3);
    drain(0, 100);

    // Start again mid-sequence and change rodada: must be ignored
    mem0[0] = 4'b1100; mem0[1] = 4'b0011;
    start0(1);
    repeat (3) @(posedge clock);
    #1;
    bus0.rodada  = 4'd5;
    bus0.iniciar = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    bus0.iniciar = 1'b0;
    drain(0, 100);

    // mem_dado changing while lit does not alter leds
    mem0[0] = 4'b1010;
    start0(0);
    repeat (2) @(posedge clock);
    #1;
    mem0[0] = 4'b0101;
    drain(0, 100);

    // iniciar held through FIM: one OCIOSO cycle, then a restart
    mem0[0] = 4'b0110;
    bus0.rodada  = 4'd0;
    bus0.iniciar = 1'b1;
    @(posedge clock);
    #1;
    push_trace(0, 0, TON0, TOFF0);
    put(0, {4'd0, 4'd0, 1'b0, 1'b0, 4'd0});
    push_trace(0, 0, TON0, TOFF0);
    repeat (10) @(posedge clock);
    #1;
    bus0.iniciar = 1'b0;
    drain(0, 100);

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) mem0[i] = 4'($urandom_range(0, 15));
      start0($urandom_range(0, 4));
      drain(0, 200);
    end

    // Asynchronous reset in the middle of ACESO
    mem0[0] = 4'b1111; mem0[1] = 4'b1001; mem0[2] = 4'b0111;
    start0(2);
    @(posedge clock);
    #2;
    reset = 1'b0;
    sb0.delete();
    #1;
    n_checks++;
    if ({bus0.leds, bus0.pronto, bus0.ocupado, bus0.mem_endereco} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: got leds=%b pronto=%b ocupado=%b addr=%0d, expected all zero",
               bus0.leds, bus0.pronto, bus0.ocupado, bus0.mem_endereco);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (bus0.db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL state_after_reset: got %0d, expected 0", bus0.db_estado);
    end

    // Full 16-step round on the short-timing instance
    for (int i = 0; i < 16; i++) mem1[i] = 4'($urandom_range(1, 15));
    bus1.rodada  = 4'd15;
    bus1.iniciar = 1'b1;
    @(posedge clock);
    #1;
    bus1.iniciar = 1'b0;
    push_trace(1, 15, TON1, TOFF1);
    drain(1, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
